uart_tx_cfg: RTL

Parametrised UART transmitter with configurable data width, runtime stop-bit count and baud divisor, and an input FIFO that decouples the producer from the line rate. It serialises LSB-first frames onto one TX line. It sits between a byte/word producer (CPU bridge, debug streamer) and the board UART pin. It supersedes the single-byte, fixed-8N1 transmitter.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_cfg_if.sv | 21 ++
 rtl/uart_fifo.sv | 61 ++++++
 rtl/uart_tx_cfg.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
// Consumed by uart_tx_cfg and the future receive block.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Frame length in bit periods: start + data + parity + stop bits.
    function automatic int frame_bits(
        input int   dw,
        input logic stop2,
        input logic par_en
    );
        return 1 + dw + (par_en ? 1 : 0) + (stop2 ? 2 : 1);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side valid/ready word handshake for uart_tx_cfg.
// The producer is the master; the transmitter is the slave.
interface uart_tx_cfg_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous single-clock FIFO with fall-through head output.
// Push is ignored when full, pop is ignored when empty.
module uart_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_level == LVL_FULL);
    assign empty  = (r_level == '0);
    assign level  = r_level;
    assign dout   = r_mem[r_rd];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage array; contents need no reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// FIFO-buffered UART transmitter, LSB first, runtime baud/stop config.
// Define UART_TX_PARITY_EN to build the parity bit logic.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 4,
    parameter  int DIV_W      = 16,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] clkdiv,
    input  logic             stop2,
    input  logic [1:0]       parity_mode,
    uart_tx_cfg_if.slave     s_if,
    output logic             tx,
    output logic             busy,
    output logic [LW-1:0]    level
);
    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_e         r_state;
    logic              r_tx;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [BW-1:0]     r_bit;
    logic              r_stop2;
    logic              r_stop_idx;
`ifdef UART_TX_PARITY_EN
    logic              r_par_en;
    logic              r_par;
`else
    logic              w_unused_pmode;
    assign w_unused_pmode = ^parity_mode;
`endif

    logic [DATA_W-1:0] w_dout;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_bit_end;

    assign w_pop     = (r_state == IDLE) && !w_empty;
    assign w_bit_end = (r_cnt == '0);

    uart_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_if.valid),
        .pop   (w_pop),
        .din   (s_if.data),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    assign s_if.ready = !w_full;
    assign tx         = r_tx;
    assign busy       = (r_state != IDLE) || (level != '0);

    // Frame sequencer: latches config at pop, shifts bits at the divided rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_div      <= '0;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_bit      <= '0;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_en   <= 1'b0;
            r_par      <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift <= w_dout;
                        r_div   <= clkdiv;
                        r_cnt   <= clkdiv;
                        r_stop2 <= stop2;
`ifdef UART_TX_PARITY_EN
                        r_par_en <= (parity_mode == PAR_EVEN)
                                 || (parity_mode == PAR_ODD);
                        r_par    <= (^w_dout)
                                 ^ (parity_mode == PAR_ODD);
`endif
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt   <= r_div;
                        r_tx    <= r_shift[0];
                        r_bit   <= '0;
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= r_div;
                        if (r_bit == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            if (r_par_en) begin
                                r_tx    <= r_par;
                                r_state <= PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_stop_idx <= 1'b0;
                                r_state    <= STOP;
                            end
`else
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
                            r_state    <= STOP;
`endif
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_cnt      <= r_div;
                        r_tx       <= 1'b1;
                        r_stop_idx <= 1'b0;
                        r_state    <= STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        if (r_stop2 && !r_stop_idx) begin
                            r_stop_idx <= 1'b1;
                            r_cnt      <= r_div;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
